// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : DES S-box tables, P permutation and reference helpers shared by
//            the S-box engine and its lanes.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Each box is stored row-major: entry (row*16 + column)
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7,
          4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8,
          4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0,
          4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD},
        '{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA,
          4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5,
          4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF,
          4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9},
        '{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8,
          4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1,
          4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7,
          4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC},
        '{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF,
          4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9,
          4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4,
          4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE},
        '{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9,
          4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6,
          4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE,
          4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3},
        '{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB,
          4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8,
          4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6,
          4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD},
        '{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1,
          4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6,
          4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2,
          4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC},
        '{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7,
          4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2,
          4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8,
          4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB}
    };

    localparam int P_TABLE [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // Raw 6-bit group b1..b6 -> table entry {b1,b6, b2..b5}
    function automatic logic [5:0] sbox_index(input logic [5:0] v);
        return {v[5], v[0], v[4:1]};
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = x[32-P_TABLE[i]];
        end
        return r;
    endfunction

    function automatic logic [31:0] des_sbox_ref(input logic [47:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[31-4*b -: 4] = SBOX[b][sbox_index(x[47-6*b -: 6])];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_lane.sv
`default_nettype none
// ============================================================================
// Module   : des_sbox_lane
// Brief    : One combinational DES S-box lookup with a selectable box.
// Revision : 1.0 - initial release
// ============================================================================
module des_sbox_lane
    import des_pkg::*;
(
    input  logic [2:0] i_box,
    input  logic [5:0] i_sel,
    output logic [3:0] o_nibble
);

    assign o_nibble = SBOX[i_box][sbox_index(i_sel)];

endmodule
`default_nettype wire

// File: rtl/des_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : des_sbox_engine
// Brief    : Handshaked DES S1..S8 substitution, time-sharing SBOX_PER_CYCLE
//            lookup lanes over 8/SBOX_PER_CYCLE cycles, optional P permutation.
// Revision : 1.0 - initial release
// ============================================================================
module des_sbox_engine
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 8,
    parameter int APPLY_P        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic        busy
);

    localparam int c_steps  = 8 / SBOX_PER_CYCLE;
    localparam int c_step_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_step_w-1:0] c_last = c_step_w'(c_steps - 1);

    generate
        if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
            SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_lanes
            $error("des_sbox_engine: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [c_step_w-1:0]   r_step;
    logic [47:0]           r_operand;
    logic [31:0]           r_result;
    // Separate output copy so dout only moves when a finished result lands
    logic [31:0]           r_hold;
    logic [31:0]           w_result_next;
    logic                  w_accept;
    logic [2:0]            w_box    [SBOX_PER_CYCLE];
    logic [5:0]            w_sel    [SBOX_PER_CYCLE];
    logic [3:0]            w_nibble [SBOX_PER_CYCLE];

    generate
        for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lane
            logic [47:0] w_aligned;
            assign w_box[j]   = 3'(int'(r_step) * SBOX_PER_CYCLE + j);
            assign w_aligned  = r_operand << (6 * int'(w_box[j]));
            assign w_sel[j]   = w_aligned[47:42];

            des_sbox_lane u_lane (
                .i_box    (w_box[j]),
                .i_sel    (w_sel[j]),
                .o_nibble (w_nibble[j])
            );
        end
    endgenerate

    always_comb begin
        w_result_next = r_result;
        for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
            w_result_next[31 - 4*int'(w_box[j]) -: 4] = w_nibble[j];
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_step == c_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_next = in_valid ? ST_BUSY : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) w_state_next = ST_IDLE;
    end

    assign w_accept = in_valid & in_ready & ~flush;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_operand <= '0;
            r_result  <= '0;
            r_hold    <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_step   <= '0;
                r_result <= '0;
                r_hold   <= '0;
            end else if (w_accept) begin
                r_operand <= din;
                r_step    <= '0;
                if (r_state == ST_IDLE) r_result <= '0;
            end else if (r_state == ST_BUSY) begin
                r_result <= w_result_next;
                if (r_step == c_last) r_hold <= w_result_next;
                else                  r_step <= r_step + 1'b1;
            end
        end
    end

    generate
        if (APPLY_P != 0) begin : g_perm
            assign dout = des_p(r_hold);
        end else begin : g_raw
            assign dout = r_hold;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_sbox_engine
// Brief    : Self-checking bench for des_sbox_engine over S in {1,2,4,8} and
//            both P settings, against an independent table-driven model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_sbox_engine;

    localparam int NCFG = 8;   // cfg k: S = 1 << (k%4), APPLY_P = k/4

    logic        clk;
    logic        rst_n;
    logic        in_valid_a  [NCFG];
    logic        in_ready_a  [NCFG];
    logic [47:0] din_a       [NCFG];
    logic        flush_a     [NCFG];
    logic        out_valid_a [NCFG];
    logic        out_ready_a [NCFG];
    logic [31:0] dout_a      [NCFG];
    logic        busy_a      [NCFG];

    int errors;
    int checks;

    logic [255:0] tb_sb [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    int tb_ptab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                         2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    generate
        for (genvar k = 0; k < NCFG; k++) begin : g_dut
            des_sbox_engine #(
                .SBOX_PER_CYCLE (1 << (k % 4)),
                .APPLY_P        (k / 4)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_a[k]),
                .in_ready  (in_ready_a[k]),
                .din       (din_a[k]),
                .flush     (flush_a[k]),
                .out_valid (out_valid_a[k]),
                .out_ready (out_ready_a[k]),
                .dout      (dout_a[k]),
                .busy      (busy_a[k])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int steps_of(input int k);
        return 8 >> (k % 4);
    endfunction

    function automatic logic [31:0] ref_sbox(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  v;
        int          idx;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            v   = 6'(x >> (42 - 6*b));
            idx = (int'(v[5]) * 2 + int'(v[0])) * 16 + int'(v[4:1]);
            r   = {r[27:0], tb_sb[b][255 - 4*idx -: 4]};
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_p(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[31-i] = x[32 - tb_ptab[i]];
        return r;
    endfunction

    function automatic logic [31:0] model(input int k, input logic [47:0] x);
        return (k >= 4) ? ref_p(ref_sbox(x)) : ref_sbox(x);
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single transaction with latency, hold-while-stalled and return-to-idle checks
    task automatic run_one(input int k, input logic [47:0] x, input string tag,
                           output logic [31:0] got);
        int lat;
        @(negedge clk);
        in_valid_a[k] = 1'b1; din_a[k] = x; out_ready_a[k] = 1'b0;
        #1 check($sformatf("%s_in_ready", tag), 64'(in_ready_a[k]), 64'd1);
        @(negedge clk);
        in_valid_a[k] = 1'b0; din_a[k] = rnd48();
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            #1;
            if (out_valid_a[k]) break;
        end
        check($sformatf("%s_latency", tag), 64'(lat), 64'(steps_of(k)));
        got = dout_a[k];
        @(negedge clk);
        #1 check($sformatf("%s_hold", tag), {31'd0, out_valid_a[k], dout_a[k]}, {31'd0, 1'b1, got});
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
        #1 check($sformatf("%s_idle", tag), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 64'b010);
    endtask

    task automatic b2b(input int k, input int nres);
        logic [31:0] q [$];
        logic [31:0] e;
        int sent, recv, cyc, last_cyc;
        sent = 0; recv = 0; cyc = 0; last_cyc = -1;
        out_ready_a[k] = 1'b1;
        while (recv < nres && cyc < nres * 20) begin
            @(negedge clk);
            cyc++;
            in_valid_a[k] = (sent < nres);
            din_a[k] = rnd48();
            #1;
            if (sent >= 1 && sent < nres)
                check($sformatf("b2b%0d_in_ready", k), 64'(in_ready_a[k]), 64'(out_valid_a[k]));
            if (in_valid_a[k] && in_ready_a[k]) begin
                q.push_back(model(k, din_a[k]));
                sent++;
            end
            if (out_valid_a[k] && out_ready_a[k]) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
                check($sformatf("b2b%0d_dout", k), 64'(dout_a[k]), 64'(e));
                if (last_cyc >= 0)
                    check($sformatf("b2b%0d_interval", k), 64'(cyc - last_cyc), 64'(steps_of(k) + 1));
                last_cyc = cyc;
                recv++;
            end
        end
        check($sformatf("b2b%0d_count", k), 64'(recv), 64'(nres));
        in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_run(input int k, input int nops);
        logic [31:0] q [$];
        logic [31:0] e, prev_dout;
        logic        prev_ov, prev_or;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; prev_ov = 1'b0; prev_or = 1'b0; prev_dout = '0;
        while (recv < nops && cyc < nops * 40) begin
            @(negedge clk);
            cyc++;
            in_valid_a[k]  = (sent < nops) && ($urandom_range(3) != 0);
            din_a[k]       = rnd48();
            out_ready_a[k] = ($urandom_range(3) != 0);
            #1;
            if (out_valid_a[k] && prev_ov && !prev_or)
                check($sformatf("rnd%0d_stable", k), 64'(dout_a[k]), 64'(prev_dout));
            if (in_valid_a[k] && in_ready_a[k]) begin
                q.push_back(model(k, din_a[k]));
                sent++;
            end
            if (out_valid_a[k] && out_ready_a[k]) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
                check($sformatf("rnd%0d_dout", k), 64'(dout_a[k]), 64'(e));
                recv++;
            end
            prev_ov = out_valid_a[k]; prev_or = out_ready_a[k]; prev_dout = dout_a[k];
        end
        check($sformatf("rnd%0d_count", k), 64'(recv), 64'(nops));
        check($sformatf("rnd%0d_leftover", k), 64'(q.size()), 64'd0);
        in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
        @(negedge clk);
    endtask

    // Abort while BUSY at step 1, via flush or asynchronous reset
    task automatic abort_test(input int k, input bit use_reset);
        string       tag;
        logic [47:0] x;
        logic [31:0] got;
        tag = use_reset ? "rst_abort" : "flush_abort";
        @(negedge clk);
        in_valid_a[k] = 1'b1; din_a[k] = rnd48(); out_ready_a[k] = 1'b0;
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        @(negedge clk);
        #1 check($sformatf("%s_busy_before", tag), 64'(busy_a[k]), 64'd1);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            #1;
        end else begin
            flush_a[k] = 1'b1;
            @(negedge clk);
            flush_a[k] = 1'b0;
            #1;
        end
        check($sformatf("%s_state", tag), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 64'b010);
        check($sformatf("%s_dout", tag), 64'(dout_a[k]), 64'd0);
        repeat (6) @(negedge clk);
        #1 check($sformatf("%s_no_residue", tag), {out_valid_a[k], busy_a[k]}, 64'd0);
        x = rnd48();
        run_one(k, x, $sformatf("%s_next", tag), got);
        check($sformatf("%s_next_dout", tag), 64'(got), 64'(model(k, x)));
    endtask

    initial begin
        logic [31:0] got;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            in_valid_a[k] = 1'b0; din_a[k] = '0; flush_a[k] = 1'b0; out_ready_a[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("reset%0d_ctrl", k), {in_ready_a[k], out_valid_a[k], busy_a[k]}, 64'b100);
            check($sformatf("reset%0d_dout", k), 64'(dout_a[k]), 64'd0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < NCFG; k++) begin
            run_one(k, 48'h000000000000, $sformatf("zero%0d", k), got);
            check($sformatf("zero%0d_dout", k), 64'(got),
                  (k >= 4) ? 64'(ref_p(32'hEFA72C4D)) : 64'h00000000EFA72C4D);
            check($sformatf("zero%0d_model", k), 64'(got), 64'(model(k, 48'h0)));
        end
        for (int k = 0; k < 4; k++) begin
            run_one(k, 48'hFFFFFFFFFFFF, $sformatf("ones%0d", k), got);
            check($sformatf("ones%0d_dout", k), 64'(got), 64'h00000000D9CE3DCB);
            run_one(k, 48'h000000000001, $sformatf("s8one%0d", k), got);
            check($sformatf("s8one%0d_low", k), 64'(got[3:0]), 64'd1);
            check($sformatf("s8one%0d_high", k), 64'(got[31:4]), 64'h000000000EFA72C4);
        end

        for (int k = 0; k < NCFG; k++) b2b(k, 6);

        abort_test(1, 1'b0);
        abort_test(1, 1'b1);
        abort_test(5, 1'b0);

        for (int k = 4; k < NCFG; k++) rand_run(k, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_sbox_engine.md
# des_sbox_engine

Parametrised DES substitution engine: accepts a 48-bit expanded-and-key-mixed half-block, applies S1..S8 and returns the 32-bit result, optionally through the P permutation. It replaces the eight standalone combinational S-box lookups in the round datapath with one handshaked unit. The unit time-shares `SBOX_PER_CYCLE` lookup lanes over 8/`SBOX_PER_CYCLE` cycles, so area and latency can be traded per build.

## Interface
- `SBOX_PER_CYCLE`, 8, lookup lanes instantiated per cycle. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.
- `APPLY_P`, 1, 1 = apply the DES P permutation to the result; 0 = raw S1..S8 concatenation.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `din` is valid.
- `in_ready` output 1: engine can accept `din` this cycle.
- `din` input 48: bit 47 is DES bit 1. `din[47:42]` feeds S1, …, `din[5:0]` feeds S8.
- `flush` input 1: synchronous abort. Drops any in-flight or held result.
- `out_valid` output 1: `dout` is valid.
- `out_ready` input 1: consumer accepts `dout`.
- `dout` output 32: bit 31 is DES bit 1. S1 occupies `[31:28]`, S8 occupies `[3:0]`, before P.
- `busy` output 1: high when the state is not IDLE.

## Operation
- Lookup per 6-bit group b[1:6]: row = {b1,b6}, column = b[2:5], output is the standard DES table nibble.
- N = 8/`SBOX_PER_CYCLE` steps. The step counter is `$clog2(N)` bits wide (1 bit minimum) and runs 0..N-1 with no wrap.
- Step k processes S-boxes k·S+1 … k·S+S, where S = `SBOX_PER_CYCLE`. Lane j of step k uses box k·S+j+1 and the matching 6-bit slice.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch `din` into the operand register, clear the result register, set step=0, go to BUSY.
  - BUSY: each cycle, write S nibbles into the result register at their final positions and increment step. When step=N-1, go to DONE.
  - DONE: `out_valid`=1, `dout` is stable. `in_ready` = `out_ready`.
    - On `out_ready` with `in_valid`: latch the new operand and go to BUSY (back-to-back).
    - On `out_ready` without `in_valid`: go to IDLE.
    - Without `out_ready`: hold.
- `in_ready` is 0 in BUSY. `din` is ignored whenever `in_ready`=0.
- When `APPLY_P`=1, P is applied combinationally from the result register to `dout`. It is pure wiring, so it adds no cycle.
- `flush`, any state: next state is IDLE, the result register is cleared, and no handshake completes that cycle. `flush` takes priority over `in_valid` and `out_ready`.
- Asynchronous reset mid-operation: immediately forces IDLE. The partial result is discarded and not resumed.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `dout`=32'h0 (or P(0)=0).
  - state=IDLE, step=0, operand register=0.
- Latency: an operand accepted on edge e makes `out_valid` high after edge e+N. For S=8 this is 1 cycle; for S=1 it is 8 cycles.
- Throughput:
  - One result per N+1 cycles when back-to-back through DONE.
  - One result per N+2 cycles when returning through IDLE.
- `dout` changes only on the edge that enters DONE or the edge that leaves DONE through flush or reset. It never glitches while `out_valid`=1.
- `out_valid` with `out_ready` low holds indefinitely, with no timeout.

## Structure
- Package `des_pkg` holds:
  - the S1..S8 tables as `logic [3:0] SBOX [8][64]`, indexed by the raw 6-bit input in {row, column} order already resolved;
  - the P permutation constant `P_TABLE[32]`;
  - a function `des_p(logic[31:0])`;
  - a bench reference function `des_sbox_ref(logic[47:0])`.
- Sub-module `des_sbox_lane`: combinational; inputs a 3-bit box index and a 6-bit value; outputs a 4-bit nibble. The engine instantiates `SBOX_PER_CYCLE` copies.
- FSM, step counter and result register live in `des_sbox_engine`.

## Test plan
- Run every directed case for S ∈ {1,2,4,8}.
- `APPLY_P`=0, `din`=48'h000000000000 → `dout`=32'hEFA72C4D, `out_valid` after exactly N edges.
- `APPLY_P`=0, `din`=48'hFFFFFFFFFFFF → `dout`=32'hD9CE3DCB.
- `APPLY_P`=0, `din`=48'h000000000001 (S8 input 000001) → `dout[3:0]`=4'd1 and `dout[31:4]`=28'hEFA72C4.
- `APPLY_P`=1, 1000 random operands with random `in_valid`/`out_ready` stalls → `dout` == `des_p(des_sbox_ref(din))`, in order, no loss or duplication.
- Back-to-back: hold `in_valid`=1 and `out_ready`=1 continuously.
  - Results every N+1 cycles.
  - `in_ready` high only in DONE and IDLE.
- `flush` and `rst_n` pulsed during BUSY step 1 (S=2).
  - Engine returns to IDLE with `out_valid`=0 and `dout`=0.
  - The next operand yields a correct result with no residue from the aborted one.
